// File: rtl/aes_key_expansion_seq.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry key store,
// with a zero-latency read mux selected by round_count.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign y = SBOX[a];
endmodule

module aes_key_expansion_seq #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          key_expan_en,
  input  logic [KW-1:0] Key_In,
  input  logic [3:0]    round_count,
  output logic [KW-1:0] round_key,
  output logic          key_expan_done,
  output logic          Key_VLD,
  output logic          busy
);
  localparam logic [3:0] NR_C = 4'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t        state, state_nxt;
  logic          en_q, start;
  logic [3:0]    rnd_cnt, rnd_nxt;
  logic          done_nxt, vld_nxt, busy_nxt, load_key, wr_rk;
  logic [KW-1:0] rk [0:NR];
  logic [KW-1:0] prev_rk, next_rk;
  logic [31:0]   rot, sub, temp, n0, n1, n2, n3;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1b;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

  assign start = key_expan_en & ~en_q;

  // One full round of the schedule; rnd_cnt is 1..NR whenever the result is stored.
  assign prev_rk = rk[rnd_cnt - 4'd1];
  assign rot     = {prev_rk[23:0], prev_rk[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
  end

  assign temp    = sub ^ {rcon_of(rnd_cnt), 24'h0};
  assign n0      = prev_rk[127:96] ^ temp;
  assign n1      = prev_rk[95:64]  ^ n0;
  assign n2      = prev_rk[63:32]  ^ n1;
  assign n3      = prev_rk[31:0]   ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd_cnt;
    done_nxt  = 1'b0;
    vld_nxt   = Key_VLD;
    busy_nxt  = busy;
    load_key  = 1'b0;
    wr_rk     = 1'b0;
    case (state)
      IDLE, READY: begin
        if (start) begin
          load_key  = 1'b1;
          rnd_nxt   = 4'd1;
          vld_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (!key_expan_en) begin
          state_nxt = IDLE;
          rnd_nxt   = 4'd0;
          vld_nxt   = 1'b0;
          busy_nxt  = 1'b0;
        end else begin
          wr_rk = 1'b1;
          if (rnd_cnt == NR_C) begin
            done_nxt  = 1'b1;
            vld_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            rnd_nxt   = 4'd0;
            state_nxt = READY;
          end else begin
            rnd_nxt = rnd_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      rnd_cnt        <= 4'd0;
      en_q           <= 1'b0;
      key_expan_done <= 1'b0;
      Key_VLD        <= 1'b0;
      busy           <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      state          <= state_nxt;
      rnd_cnt        <= rnd_nxt;
      en_q           <= key_expan_en;
      key_expan_done <= done_nxt;
      Key_VLD        <= vld_nxt;
      busy           <= busy_nxt;
      if (load_key) rk[0] <= Key_In;
      for (int i = 1; i <= NR; i++)
        if (wr_rk && rnd_cnt == 4'(i)) rk[i] <= next_rk;
    end
  end

  // Reads are gated so a partial or stale schedule is never visible.
  always_comb begin
    round_key = '0;
    if (Key_VLD && round_count <= NR_C) round_key = rk[round_count];
  end
endmodule

// File: tb/tb_aes_key_expansion_seq.sv
// Self-checking bench: FIPS-197 vectors plus random keys against a word-level
// key-schedule model whose S-box is derived from GF(2^8) inversion and the affine map.

module tb_aes_key_expansion_seq;
  logic         CLK = 1'b0;
  logic         RST;
  logic         key_expan_en;
  logic [127:0] Key_In;
  logic [3:0]   round_count;
  logic [127:0] round_key;
  logic         key_expan_done;
  logic         Key_VLD;
  logic         busy;

  int errors = 0;
  int checks = 0;
  logic [127:0] ref_rk [0:10];

  always #5 CLK = ~CLK;

  aes_key_expansion_seq #(.NR(10), .KW(128)) dut (
    .CLK(CLK), .RST(RST), .key_expan_en(key_expan_en), .Key_In(Key_In),
    .round_count(round_count), .round_key(round_key),
    .key_expan_done(key_expan_done), .Key_VLD(Key_VLD), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    repeat (254) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t ^= {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic read_key(input logic [3:0] rc, output logic [127:0] k);
    round_count = rc;
    #1;
    k = round_key;
  endtask

  task automatic drop_en();
    key_expan_en = 1'b0;
    step();
  endtask

  // Starts an expansion (en assumed low on the previous edge), optionally
  // corrupting Key_In at EXPAND cycle change_at, then checks latency and every key.
  task automatic do_expand(input logic [127:0] key, input int change_at);
    int n = 0;
    logic [127:0] k;
    model_expand(key);
    Key_In = key;
    key_expan_en = 1'b1;
    while (n < 20) begin
      step();
      n++;
      if (n == 1) chk("busy_during", 128'(busy), 128'(1));
      if (n == change_at) Key_In = rand_key();
      if (key_expan_done) break;
    end
    chk("done_latency", 128'(n), 128'(11));
    chk("vld_at_done", 128'(Key_VLD), 128'(1));
    chk("busy_at_done", 128'(busy), 128'(0));
    step();
    chk("done_one_cycle", 128'(key_expan_done), 128'(0));
    for (int r = 0; r <= 10; r++) begin
      read_key(4'(r), k);
      chk($sformatf("rk%0d", r), k, ref_rk[r]);
    end
  endtask

  initial begin
    logic [127:0] k;
    int pulses;
    RST = 1'b1;
    key_expan_en = 1'b0;
    Key_In = 128'h0;
    round_count = 4'd0;
    step();
    step();
    chk("rst_done", 128'(key_expan_done), 128'(0));
    chk("rst_vld", 128'(Key_VLD), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    read_key(4'd0, k);
    chk("rst_rk0", k, 128'h0);
    RST = 1'b0;
    step();

    // FIPS-197 key, then en held high in READY
    do_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, -1);
    read_key(4'd1, k);  chk("fips_rk1", k, 128'ha0fafe1788542cb123a339392a6c7605);
    read_key(4'd10, k); chk("fips_rk10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_key(4'd0, k);  chk("fips_rk0", k, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (key_expan_done) pulses++;
    end
    chk("hold_no_retrigger", 128'(pulses), 128'(0));
    read_key(4'd10, k); chk("hold_rk10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // back-to-back with all-zero key
    drop_en();
    do_expand(128'h0, -1);
    read_key(4'd10, k); chk("zero_rk10", k, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    drop_en();
    do_expand(128'h000102030405060708090a0b0c0d0e0f, -1);
    read_key(4'd10, k); chk("seq_rk10", k, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("seq_vld", 128'(Key_VLD), 128'(1));
    for (int r = 11; r <= 15; r++) begin
      read_key(4'(r), k);
      chk($sformatf("oor_rc%0d", r), k, 128'h0);
    end

    // abort at EXPAND cycle 5
    drop_en();
    Key_In = rand_key();
    key_expan_en = 1'b1;
    repeat (5) step();
    chk("abort_busy_before", 128'(busy), 128'(1));
    key_expan_en = 1'b0;
    step();
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_vld", 128'(Key_VLD), 128'(0));
    read_key(4'd0, k); chk("abort_rk0", k, 128'h0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (key_expan_done) pulses++;
    end
    chk("abort_no_done", 128'(pulses), 128'(0));

    // reset at EXPAND cycle 7, then RST concurrent with a start
    Key_In = rand_key();
    key_expan_en = 1'b1;
    repeat (7) step();
    RST = 1'b1;
    key_expan_en = 1'b0;
    step();
    chk("midrst_done", 128'(key_expan_done), 128'(0));
    chk("midrst_vld", 128'(Key_VLD), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    read_key(4'd10, k); chk("midrst_rk10", k, 128'h0);
    key_expan_en = 1'b1;
    step();
    chk("rst_wins_busy", 128'(busy), 128'(0));
    RST = 1'b0;
    do_expand(128'h000102030405060708090a0b0c0d0e0f, -1);

    // Key_In disturbed during EXPAND cycle 3
    drop_en();
    do_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 3);
    read_key(4'd10, k); chk("keyin_ignored_rk10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int t = 0; t < 4; t++) begin
      drop_en();
      do_expand(rand_key(), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_key_expansion_seq.md
Name: aes_key_expansion_seq

Overview:
Iterative AES-128 key schedule that sits directly upstream of the encryption control FSM and the AddRoundKey datapath. It is started by key_expan_en and computes one 128-bit round key per clock, rounds 1..10. It stores all 11 round keys and returns key_expan_done to the FSM. The AddRoundKey stage then reads keys indexed by the FSM's round_count.

Parameters:
NR, 10, number of rounds (AES-128 only; other values unsupported)
KW, 128, key and round-key width in bits

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
key_expan_en  input  1  level from FSM, high while FSM is in KEY_EXPANSION
Key_In  input  128  cipher key; byte 0 = Key_In[127:120]
round_count  input  4  round-key select from FSM, valid range 0..10
round_key  output  128  selected round key (combinational mux of key store)
key_expan_done  output  1  registered one-cycle completion pulse
Key_VLD  output  1  high while the key store holds a complete, valid schedule
busy  output  1  high during expansion

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high (RST sampled on CLK rising edge).
- Values in reset: state=IDLE; key_expan_done=0; Key_VLD=0; busy=0; rnd_cnt=0; en_q=0; key store cleared to 0; round_key therefore reads 0.
- en_q: registered copy of key_expan_en; start = key_expan_en & ~en_q (rising edge).
- State IDLE:
  - On start: latch Key_In into rk[0] and set rnd_cnt=1.
  - Set Key_VLD=0 and busy=1, then go to EXPAND.
- State EXPAND, each cycle: rk[rnd_cnt] = f(rk[rnd_cnt-1], Rcon[rnd_cnt]).
  - f: temp = SubWord(RotWord(w3)) ^ {Rcon,24'h0}.
  - w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - Chaining of all four words is combinational within the cycle.
  - SubWord uses four combinational instances of the codebase S-box, shared definition with the SubBytes stage.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - rnd_cnt increments after each round. When round NR is written: key_expan_done=1 for exactly that next cycle, Key_VLD=1, busy=0, state goes to READY.
- Latency: start sampled at edge E0; rk[10] is written at edge E10; key_expan_done is high during the cycle after E10. Total 11 cycles from enable to done.
- State READY:
  - Keys hold; key_expan_done=0.
  - A new start (en low then high again) behaves exactly as from IDLE, re-latching Key_In. This re-expands for every encryption, even with an unchanged key.
  - key_expan_en held high in READY does not retrigger.
- Abort: key_expan_en low while in EXPAND goes to IDLE next cycle. Key_VLD stays 0, no done pulse, busy=0, and partial keys are not flagged valid.
- Key_In changes after the start cycle are ignored.
- round_key output:
  - Equals rk[round_count] when round_count<=10 and Key_VLD=1.
  - Equals 0 when round_count>10 or Key_VLD=0.
  - Purely combinational from round_count to round_key, with zero-cycle latency.
- Reset mid-expansion: the next cycle matches the reset values exactly; no done pulse is issued.
- Simultaneous start and RST: RST wins.
- All XOR arithmetic is bitwise and width-exact. rnd_cnt is 4 bits and never exceeds 10.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, en held high -> done pulse exactly 11 cycles after start for 1 cycle. round_count=1 reads a0fafe1788542cb123a339392a6c7605; round_count=10 reads d014f9a8c9ee2589e13f0cc8b6630ca6; round_count=0 reads the key.
- Key 000102030405060708090a0b0c0d0e0f -> round_count=10 reads 13111d7fe3944a17f307a78b4d2b30c5; Key_VLD=1; round_count=11..15 reads 0.
- Back-to-back: after first done, drop en 1 cycle, raise with key 00..00 -> second done after 11 cycles; round_count=10 reads b4ef5bcb3e92e21123e951cf6f8f188e.
- Abort: drop en at cycle 5 of EXPAND -> busy=0 next cycle, Key_VLD=0, round_key=0, no done pulse.
- Reset: assert RST at cycle 7 of expansion -> next cycle all outputs 0 and state IDLE; subsequent start expands normally.
- Hold en high in READY for 20 cycles -> no further done pulse; keys unchanged. Change Key_In in cycle 3 of EXPAND -> results identical to the original-key vectors.
